// File: rtl/fifo_access_arbiter.sv
// Access controller for a small single-clock FIFO datapath: round-robin write-port
// arbitration among NUM_REQ producers, single-word pop sequencing and occupancy tracking.
module fifo_access_arbiter #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NUM_REQ-1:0]    i_req,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic                  o_wr_en,
  output logic [1:0]            o_wr_sel,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  input  logic                  i_rd_req,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_rd_valid,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {W_ARB, W_WRITE} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_VALID} rd_state_t;

  wr_state_t             r_wr_state, w_wr_state;
  rd_state_t             r_rd_state, w_rd_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, w_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr, w_rd_ptr;
  logic [CW-1:0]         r_count, w_count;
  logic [IW-1:0]         r_last, w_last;
  logic [NUM_REQ-1:0]    r_grant, w_grant;
  logic                  r_wr_en, w_wr_en;
  logic [1:0]            r_wr_sel, w_wr_sel;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr;
  logic                  r_rd_en, w_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr;
  logic                  r_rd_valid, w_rd_valid;
  logic                  w_full, w_empty;
  logic                  w_pick_found;
  logic [IW-1:0]         w_pick_idx;
  logic [IW-1:0]         w_scan;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Round-robin scan starting just after the last granted requester
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_scan       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_scan = IW'((32'(r_last) + 32'd1 + k) % NUM_REQ);
      if (!w_pick_found && i_req[w_scan]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_scan;
      end
    end
  end

  // Next-state and next-output logic for both FSMs and the occupancy counter
  always_comb begin
    w_wr_state = r_wr_state;
    w_rd_state = r_rd_state;
    w_wr_ptr   = r_wr_ptr;
    w_rd_ptr   = r_rd_ptr;
    w_count    = r_count;
    w_last     = r_last;
    w_grant    = '0;
    w_wr_en    = 1'b0;
    w_wr_sel   = r_wr_sel;
    w_wr_addr  = r_wr_addr;
    w_rd_en    = 1'b0;
    w_rd_addr  = r_rd_addr;
    w_rd_valid = 1'b0;

    unique case (r_wr_state)
      W_ARB: begin
        if (w_pick_found && !w_full) begin
          w_wr_state = W_WRITE;
          w_grant    = NUM_REQ'(1) << w_pick_idx;
          w_wr_en    = 1'b1;
          w_wr_sel   = 2'(w_pick_idx);
          w_wr_addr  = r_wr_ptr;
        end
      end
      W_WRITE: begin
        w_wr_state = W_ARB;
        w_wr_ptr   = r_wr_ptr + ADDR_WIDTH'(1);
        w_last     = IW'(r_wr_sel);
      end
      default: w_wr_state = W_ARB;
    endcase

    unique case (r_rd_state)
      R_IDLE: begin
        if (i_rd_req && !w_empty) begin
          w_rd_state = R_ISSUE;
          w_rd_en    = 1'b1;
          w_rd_addr  = r_rd_ptr;
        end
      end
      R_ISSUE: begin
        w_rd_state = R_VALID;
        w_rd_valid = 1'b1;
        w_rd_ptr   = r_rd_ptr + ADDR_WIDTH'(1);
      end
      R_VALID: w_rd_state = R_IDLE;
      default: w_rd_state = R_IDLE;
    endcase

    unique case ({r_wr_state == W_WRITE, r_rd_state == R_ISSUE})
      2'b10:   w_count = r_count + CW'(1);
      2'b01:   w_count = r_count - CW'(1);
      default: w_count = r_count;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_state <= W_ARB;
      r_rd_state <= R_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_last     <= IW'(NUM_REQ - 1);
      r_grant    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= '0;
      r_wr_addr  <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state;
      r_rd_state <= w_rd_state;
      r_wr_ptr   <= w_wr_ptr;
      r_rd_ptr   <= w_rd_ptr;
      r_count    <= w_count;
      r_last     <= w_last;
      r_grant    <= w_grant;
      r_wr_en    <= w_wr_en;
      r_wr_sel   <= w_wr_sel;
      r_wr_addr  <= w_wr_addr;
      r_rd_en    <= w_rd_en;
      r_rd_addr  <= w_rd_addr;
      r_rd_valid <= w_rd_valid;
    end
  end

  assign o_grant    = r_grant;
  assign o_wr_en    = r_wr_en;
  assign o_wr_sel   = r_wr_sel;
  assign o_wr_addr  = r_wr_addr;
  assign o_rd_en    = r_rd_en;
  assign o_rd_addr  = r_rd_addr;
  assign o_rd_valid = r_rd_valid;
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Bench for fifo_access_arbiter: a behavioural datapath and producers around the DUT,
// a reference model for pointers/occupancy/round-robin, and a data-order scoreboard.
module tb_fifo_access_arbiter;

  localparam int unsigned AW    = 2;
  localparam int unsigned NR    = 2;
  localparam int          DEPTH = 4;

  logic          clk = 1'b0;
  logic          i_reset;
  logic [NR-1:0] i_req;
  logic [NR-1:0] o_grant;
  logic          o_wr_en;
  logic [1:0]    o_wr_sel;
  logic [AW-1:0] o_wr_addr;
  logic          i_rd_req;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic          o_rd_valid;
  logic [AW:0]   o_count;
  logic          o_full;
  logic          o_empty;

  always #5 clk = ~clk;

  fifo_access_arbiter #(.ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_req(i_req), .o_grant(o_grant),
    .o_wr_en(o_wr_en), .o_wr_sel(o_wr_sel), .o_wr_addr(o_wr_addr),
    .i_rd_req(i_rd_req), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .o_rd_valid(o_rd_valid), .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );

  // Behavioural datapath: storage plus registered read port
  logic [7:0] data_r [NR];
  logic [7:0] mem [DEPTH];
  logic [7:0] rd_dout;
  always @(posedge clk) begin
    if (o_wr_en) mem[o_wr_addr] <= data_r[o_wr_sel[0]];
    if (o_rd_en) rd_dout <= mem[o_rd_addr];
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int m_count, m_wr_ptr, m_rd_ptr, m_last;
  int n_rd_valid;
  bit prev_rd_en;
  bit adv [NR];
  logic [7:0] q_exp [$];
  int wr_hist [$];
  int rd_hist [$];
  int sel_hist [$];
  int grant_cyc [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-cycle reference model and scoreboard
  task automatic monitor();
    int pick;
    for (int r = 0; r < NR; r++) begin
      if (adv[r]) begin
        data_r[r] = data_r[r] + 8'd1;
        adv[r] = 1'b0;
      end
    end
    if (i_reset) begin
      m_count = 0; m_wr_ptr = 0; m_rd_ptr = 0; m_last = NR - 1;
      prev_rd_en = 1'b0;
      q_exp.delete();
      return;
    end
    chk("count", 32'(o_count), 32'(m_count));
    chk("full", 32'(o_full), 32'(m_count == DEPTH));
    chk("empty", 32'(o_empty), 32'(m_count == 0));
    chk("grant_onehot", 32'($countones(o_grant) <= 1), 32'd1);
    chk("wr_en_eq_grant", 32'(o_wr_en), 32'(|o_grant));
    chk("rd_valid_latency", 32'(o_rd_valid), 32'(prev_rd_en));
    if (o_wr_en) begin
      pick = -1;
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_last + 1 + k) % NR;
        if (pick < 0 && i_req[j]) pick = j;
      end
      chk("wr_not_full", 32'(m_count < DEPTH), 32'd1);
      chk("wr_addr", 32'(o_wr_addr), 32'(m_wr_ptr));
      if (pick < 0) begin
        chk("grant_without_req", 32'd0, 32'd1);
      end else begin
        chk("wr_sel", 32'(o_wr_sel), 32'(pick));
        chk("grant_bit", 32'(o_grant), 32'(1) << pick);
        q_exp.push_back(data_r[pick]);
        adv[pick] = 1'b1;
        m_last = pick;
        sel_hist.push_back(pick);
      end
      m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
      wr_hist.push_back(int'(o_wr_addr));
      grant_cyc.push_back(cyc);
    end
    if (o_rd_en) begin
      chk("rd_not_empty", 32'(m_count > 0), 32'd1);
      chk("rd_addr", 32'(o_rd_addr), 32'(m_rd_ptr));
      m_rd_ptr = (m_rd_ptr + 1) % DEPTH;
      rd_hist.push_back(int'(o_rd_addr));
    end
    if (o_rd_valid) begin
      n_rd_valid++;
      if (q_exp.size() == 0) chk("rd_underflow", 32'd0, 32'd1);
      else chk("rd_data", 32'(rd_dout), 32'(q_exp.pop_front()));
    end
    m_count = m_count + int'(o_wr_en) - int'(o_rd_en);
    prev_rd_en = o_rd_en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  // Two reset edges, then check the post-reset output state
  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_wr_en", 32'(o_wr_en), 32'd0);
    chk("rst_rd_en", 32'(o_rd_en), 32'd0);
    chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(o_rd_addr), 32'd0);
    wr_hist.delete(); rd_hist.delete(); sel_hist.delete(); grant_cyc.delete();
    n_rd_valid = 0;
    i_reset = 1'b0;
  endtask

  initial begin
    int base;
    i_reset = 1'b1; i_req = '0; i_rd_req = 1'b0;
    data_r[0] = 8'h00; data_r[1] = 8'h80;
    adv[0] = 1'b0; adv[1] = 1'b0;
    do_reset();

    // Single producer, no reads: grant every other cycle until full
    i_req = 2'b01;
    base = cyc;
    repeat (12) step();
    chk("t2_ngrant", 32'(grant_cyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_cyc.size(); i++) begin
      chk("t2_grant_cycle", 32'(grant_cyc[i] - base), 32'(2 * i + 1));
      chk("t2_wr_addr", 32'(wr_hist[i]), 32'(i));
    end
    chk("t2_count", 32'(o_count), 32'd4);
    chk("t2_full", 32'(o_full), 32'd1);

    // Traffic in both directions, then reset mid-stream
    i_req = 2'b11; i_rd_req = 1'b1;
    repeat (11) step();
    do_reset();

    // Two producers with a continuous consumer: strict alternation
    repeat (40) begin
      step();
      chk("t3_count_le_depth", 32'(o_count <= 3'(DEPTH)), 32'd1);
    end
    chk("t3_enough_grants", 32'(sel_hist.size() >= 8), 32'd1);
    for (int i = 1; i < sel_hist.size(); i++)
      chk("t3_alternate", 32'(sel_hist[i]), 32'(1 - sel_hist[i-1]));

    // Two words then drain
    i_req = '0; i_rd_req = 1'b0;
    do_reset();
    i_req = 2'b01;
    for (int i = 0; i < 20 && grant_cyc.size() < 2; i++) step();
    i_req = '0;
    chk("t4_writes", 32'(grant_cyc.size()), 32'd2);
    repeat (2) step();
    i_rd_req = 1'b1;
    repeat (12) step();
    i_rd_req = 1'b0;
    chk("t4_reads", 32'(rd_hist.size()), 32'd2);
    if (rd_hist.size() == 2) begin
      chk("t4_rd_addr0", 32'(rd_hist[0]), 32'd0);
      chk("t4_rd_addr1", 32'(rd_hist[1]), 32'd1);
    end
    chk("t4_valids", 32'(n_rd_valid), 32'd2);
    chk("t4_empty", 32'(o_empty), 32'd1);

    // Coincident write and read at count 2
    i_req = 2'b01;
    for (int i = 0; i < 20 && grant_cyc.size() < 4; i++) step();
    i_req = '0;
    repeat (2) step();
    chk("t5_pre_count", 32'(o_count), 32'd2);
    i_req = 2'b01; i_rd_req = 1'b1;
    step();
    i_req = '0; i_rd_req = 1'b0;
    chk("t5_wr_en", 32'(o_wr_en), 32'd1);
    chk("t5_rd_en", 32'(o_rd_en), 32'd1);
    chk("t5_wr_addr", 32'(o_wr_addr), 32'd0);
    chk("t5_rd_addr", 32'(o_rd_addr), 32'd2);
    step();
    chk("t5_count_hold", 32'(o_count), 32'd2);
    repeat (2) step();
    i_rd_req = 1'b1;
    repeat (12) step();
    i_rd_req = 1'b0;
    chk("t5_drained", 32'(o_empty), 32'd1);

    // Six write/read pairs across the pointer wrap
    do_reset();
    i_req = 2'b01; i_rd_req = 1'b1;
    for (int i = 0; i < 80 && n_rd_valid < 6; i++) begin
      step();
      if (grant_cyc.size() >= 6) i_req = '0;
    end
    i_rd_req = 1'b0;
    chk("t6_reads", 32'(n_rd_valid), 32'd6);
    chk("t6_writes", 32'(wr_hist.size()), 32'd6);
    for (int i = 0; i < 6 && i < wr_hist.size() && i < rd_hist.size(); i++) begin
      chk("t6_wr_addr_seq", 32'(wr_hist[i]), 32'(i % DEPTH));
      chk("t6_rd_addr_seq", 32'(rd_hist[i]), 32'(i % DEPTH));
    end
    repeat (3) step();
    chk("t6_empty", 32'(o_empty), 32'd1);
    chk("t6_scoreboard_drained", 32'(q_exp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
